// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider.
//   - op encodings for DIV/DIVU/REM/REMU
//   - FSM state type
package div_unit_pkg;

    localparam logic [1:0] OpDiv  = 2'b00;
    localparam logic [1:0] OpDivu = 2'b01;
    localparam logic [1:0] OpRem  = 2'b10;
    localparam logic [1:0] OpRemu = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StDone = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle, MSB first; the result is registered on entry to DONE.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_ni    asynchronous active-low reset
//   start_i   request, sampled only in IDLE or DONE
//   kill_i    flush: aborts an operation in flight, blocks an accept
//   op_i      operation (OpDiv/OpDivu/OpRem/OpRemu)
//   op1_i     dividend
//   op2_i     divisor
//   busy_o    high while iterating
//   done_o    one-cycle pulse, result_o valid
//   result_o  quotient or remainder, held until the next completion
//
// Configuration macro: DIV_EARLY_OUT_EN
//   When defined, divide-by-zero, signed overflow and |op1| < |op2| complete
//   directly into DONE (done on cycle 1). Otherwise every op takes Width+1 cycles.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             kill_i,
    input  logic [1:0]       op_i,
    input  logic [Width-1:0] op1_i,
    input  logic [Width-1:0] op2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] result_o
);

    localparam int unsigned CntW = $clog2(Width);
    localparam logic [CntW-1:0] CntInit = CntW'(Width - 1);

    div_state_e       state_q, state_d;
    logic             is_rem_q, is_rem_d;
    logic             div0_q, div0_d;
    logic             ovf_q, ovf_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [Width-1:0] dvd_q, dvd_d;   // dividend shifts out, quotient shifts in
    logic [Width-1:0] dvs_q, dvs_d;
    logic [Width-1:0] rem_q, rem_d;
    logic [Width-1:0] op1_q, op1_d;
    logic [Width-1:0] result_q, result_d;

    // Final result selection including special cases and sign fix.
    function automatic logic [Width-1:0] fix_result(
        input logic             is_rem,
        input logic             div0,
        input logic             ovf,
        input logic [Width-1:0] quo,
        input logic [Width-1:0] rem,
        input logic             qneg,
        input logic             rneg,
        input logic [Width-1:0] op1
    );
        logic [Width-1:0] res;
        if (div0) begin
            res = is_rem ? op1 : '1;
        end else if (ovf) begin
            res = is_rem ? '0 : op1;
        end else if (is_rem) begin
            res = rneg ? (~rem + 1'b1) : rem;
        end else begin
            res = qneg ? (~quo + 1'b1) : quo;
        end
        return res;
    endfunction

    // Operand preparation for an accept.
    logic             acc_signed, acc_is_rem, acc_op1_neg, acc_op2_neg;
    logic             acc_div0, acc_ovf, accept;
    logic [Width-1:0] acc_op1_mag, acc_op2_mag;

    always_comb begin
        acc_signed  = (op_i == OpDiv) || (op_i == OpRem);
        acc_is_rem  = (op_i == OpRem) || (op_i == OpRemu);
        acc_op1_neg = acc_signed & op1_i[Width-1];
        acc_op2_neg = acc_signed & op2_i[Width-1];
        acc_op1_mag = acc_op1_neg ? (~op1_i + 1'b1) : op1_i;
        acc_op2_mag = acc_op2_neg ? (~op2_i + 1'b1) : op2_i;
        acc_div0    = (op2_i == '0);
        acc_ovf     = acc_signed && (op1_i == {1'b1, {(Width-1){1'b0}}}) && (op2_i == '1);
        accept      = start_i && !kill_i && (state_q != StCalc);
    end

    // One restoring step; the remainder path is Width+1 bits so the borrow is exact.
    logic [Width:0]   rem_shift, rem_sub;
    logic             qbit;
    logic [Width-1:0] step_quo, step_rem;

    always_comb begin
        rem_shift = {rem_q, dvd_q[Width-1]};
        rem_sub   = rem_shift - {1'b0, dvs_q};
        qbit      = ~rem_sub[Width];
        step_quo  = {dvd_q[Width-2:0], qbit};
        step_rem  = qbit ? rem_sub[Width-1:0] : rem_shift[Width-1:0];
    end

    always_comb begin
        state_d  = state_q;
        is_rem_d = is_rem_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        op1_d    = op1_q;
        result_d = result_q;

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    state_d  = StCalc;
                    is_rem_d = acc_is_rem;
                    div0_d   = acc_div0;
                    ovf_d    = acc_ovf;
                    qneg_d   = acc_op1_neg ^ acc_op2_neg;
                    rneg_d   = acc_op1_neg;
                    cnt_d    = CntInit;
                    dvd_d    = acc_op1_mag;
                    dvs_d    = acc_op2_mag;
                    rem_d    = '0;
                    op1_d    = op1_i;
`ifdef DIV_EARLY_OUT_EN
                    if (acc_div0 || acc_ovf || (acc_op1_mag < acc_op2_mag)) begin
                        // Quotient is 0 and remainder is the dividend magnitude.
                        state_d  = StDone;
                        result_d = fix_result(acc_is_rem, acc_div0, acc_ovf, '0, acc_op1_mag,
                                              acc_op1_neg ^ acc_op2_neg, acc_op1_neg, op1_i);
                    end
`endif
                end
            end
            StCalc: begin
                if (kill_i) begin
                    state_d = StIdle;
                end else begin
                    dvd_d = step_quo;
                    rem_d = step_rem;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d  = StDone;
                        result_d = fix_result(is_rem_q, div0_q, ovf_q, step_quo, step_rem,
                                              qneg_q, rneg_q, op1_q);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            is_rem_q <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            op1_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            is_rem_q <= is_rem_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            op1_q    <= op1_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q == StCalc);
    assign done_o   = (state_q == StDone);
    assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed, table-driven bench for div_unit (Width = 32).
// Latency expectations follow DIV_EARLY_OUT_EN when it is defined for the build.
module tb_div_unit;
    import div_unit_pkg::*;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EarlyEn = 1'b1;
`else
    localparam bit EarlyEn = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i, kill_i;
    logic [1:0]  op_i;
    logic [31:0] op1_i, op2_i;
    logic        busy_o, done_o;
    logic [31:0] result_o;

    int n_cmp = 0;
    int n_err = 0;

    div_unit #(.Width(32)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .kill_i   (kill_i),
        .op_i     (op_i),
        .op1_i    (op1_i),
        .op2_i    (op2_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          early;   // qualifies for the early-out path
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues an op (accept on the next rising edge) and returns at #1 into the done cycle,
    // or after a 40-cycle budget with lat = -1.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int nbusy);
        op_i = op; op1_i = a; op2_i = b; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        lat = -1; nbusy = 0; res = 32'hDEAD_BEEF;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            if (n > 1) begin
                @(posedge clk_i); #1;
            end
            if (busy_o) nbusy++;
            if (done_o) begin
                lat = n;
                res = result_o;
            end
        end
    endtask

    vec_t        vecs[$];
    logic [31:0] res;
    int          lat, nbusy, exp_lat, exp_busy;
    bit          seen_done;

    initial begin
        vecs.push_back('{"div_m7_2",     OpDiv,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{"rem_m7_2",     OpRem,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"divu_100_0",   OpDivu, 32'd100,       32'd0,         32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{"remu_100_0",   OpRemu, 32'd100,       32'd0,         32'd100,       1'b1});
        vecs.push_back('{"div_m5_0",     OpDiv,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{"rem_m5_0",     OpRem,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b1});
        vecs.push_back('{"div_ovf",      OpDiv,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
        vecs.push_back('{"rem_ovf",      OpRem,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1});
        vecs.push_back('{"divu_max_3",   OpDivu, 32'hFFFF_FFFF, 32'd3,         32'h5555_5555, 1'b0});
        vecs.push_back('{"remu_max_7",   OpRemu, 32'hFFFF_FFFF, 32'd7,         32'd3,         1'b0});
        vecs.push_back('{"divu_3_10",    OpDivu, 32'd3,         32'd10,        32'd0,         1'b1});
        vecs.push_back('{"remu_3_10",    OpRemu, 32'd3,         32'd10,        32'd3,         1'b1});
        vecs.push_back('{"div_7_m2",     OpDiv,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{"rem_7_m2",     OpRem,  32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0});
        vecs.push_back('{"div_m100_7",   OpDiv,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0});
        vecs.push_back('{"rem_m100_7",   OpRem,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{"divu_1000_10", OpDivu, 32'd1000,      32'd10,        32'd100,       1'b0});
        vecs.push_back('{"rem_m3_10",    OpRem,  32'hFFFF_FFFD, 32'd10,        32'hFFFF_FFFD, 1'b1});

        rst_ni = 1'b0; start_i = 1'b0; kill_i = 1'b0; op_i = '0; op1_i = '0; op2_i = '0;
        repeat (2) @(negedge clk_i);
        check("reset_busy",   {31'd0, busy_o}, 32'd0);
        check("reset_done",   {31'd0, done_o}, 32'd0);
        check("reset_result", result_o,        32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Table: each op from IDLE.
        foreach (vecs[i]) begin
            exp_lat  = (EarlyEn && vecs[i].early) ? 1 : 33;
            exp_busy = (EarlyEn && vecs[i].early) ? 0 : 32;
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, nbusy);
            check({vecs[i].name, "_result"}, res, vecs[i].exp);
            check({vecs[i].name, "_latency"}, 32'(lat), 32'(exp_lat));
            check({vecs[i].name, "_busy"}, 32'(nbusy), 32'(exp_busy));
            @(negedge clk_i);
            @(negedge clk_i);
        end

        // Back-to-back: second start driven during the done cycle.
        do_op(OpDivu, 32'hFFFF_FFFF, 32'd3, res, lat, nbusy);
        check("b2b_first_result", res, 32'h5555_5555);
        do_op(OpRemu, 32'hFFFF_FFFF, 32'd7, res, lat, nbusy);
        check("b2b_second_result",  res,        32'd3);
        check("b2b_second_latency", 32'(lat),   32'd33);
        @(negedge clk_i);

        // Prior result is 3; establish 100 as the value a kill must preserve.
        do_op(OpDivu, 32'd1000, 32'd10, res, lat, nbusy);
        check("pre_kill_result", res, 32'd100);
        @(negedge clk_i);

        // Kill on cycle 10 of CALC.
        op_i = OpDiv; op1_i = 32'hFFFF_FFF9; op2_i = 32'd2; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (9) begin
            @(posedge clk_i); #1;
        end
        check("kill_busy_before", {31'd0, busy_o}, 32'd1);
        kill_i = 1'b1;
        @(posedge clk_i); #1;
        kill_i = 1'b0;
        check("kill_busy_after", {31'd0, busy_o}, 32'd0);
        check("kill_result_kept", result_o, 32'd100);
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (done_o) seen_done = 1'b1;
        end
        check("kill_no_done", {31'd0, seen_done}, 32'd0);
        check("kill_result_still", result_o, 32'd100);
        @(negedge clk_i);
        do_op(OpDiv, 32'hFFFF_FFF9, 32'd2, res, lat, nbusy);
        check("post_kill_result",  res,      32'hFFFF_FFFD);
        check("post_kill_latency", 32'(lat), 32'd33);
        @(negedge clk_i);

        // start and kill together in IDLE: no accept.
        op_i = OpDivu; op1_i = 32'd3; op2_i = 32'd10; start_i = 1'b1; kill_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0; kill_i = 1'b0;
        check("kill_blocks_busy", {31'd0, busy_o}, 32'd0);
        check("kill_blocks_done", {31'd0, done_o}, 32'd0);
        @(negedge clk_i);

        // Asynchronous reset mid-CALC.
        op_i = OpDivu; op1_i = 32'd1000; op2_i = 32'd7; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (4) begin
            @(posedge clk_i); #1;
        end
        check("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check("rst_busy",   {31'd0, busy_o}, 32'd0);
        check("rst_done",   {31'd0, done_o}, 32'd0);
        check("rst_result", result_o,        32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        do_op(OpRemu, 32'd1000, 32'd7, res, lat, nbusy);
        check("post_rst_result", res, 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
